// File: rtl/cam_burst_pkg.sv
// Shared types and constants for the camera burst write buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cam_burst_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BURST = 2'd2,
        S_FLUSH = 2'd3
    } cam_state_t;

    localparam int CAM_BURST_LEN   = 32;
    localparam int CAM_FIFO_DEPTH  = 64;
    // Word address stride between consecutive camera bursts, shared with the arbiter.
    localparam int CAM_ADDR_STRIDE = 32;

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// Latency: a push is visible on pop_data/count the cycle after the write edge.
// Backpressure: push while full is ignored unless a pop frees the slot in the same cycle.
// Ports: clk, rst (async high), clr (sync), push/push_data, pop/pop_data,
//        full, empty, count (occupancy, $clog2(DEPTH)+1 bits).
module cam_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // A pop on an empty FIFO is a no-op; a pop on a full FIFO makes room for a push.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cam_burst_buf.sv
// Camera write buffer: packs byte pairs into 16-bit words, requests SDRAM bursts, flushes on vsync.
// Latency: word visible one cycle after its second byte; cam_req high two cycles after count reaches BURST_LEN.
// Backpressure: none upstream; words arriving while the FIFO is full are dropped and flagged in overflow.
// Ports: clk80, rst (async high); pix_data/pix_valid/vsync from camera; go/wr/data_rd from arbiter
//        and memory controller; wr_data (FIFO head), cam_req, sticky overflow/underflow.
// Build option: CAM_BYTE_SWAP_EN places the first byte of a pair in [7:0] instead of [15:8].
module cam_burst_buf
    import cam_burst_pkg::*;
#(
    parameter int BURST_LEN = CAM_BURST_LEN,
    parameter int DEPTH     = CAM_FIFO_DEPTH
) (
    input  logic        clk80,
    input  logic        rst,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    input  logic        vsync,
    input  logic        go,
    input  logic        wr,
    input  logic        data_rd,
    output logic [15:0] wr_data,
    output logic        cam_req,
    output logic        overflow,
    output logic        underflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] BURST_WORDS = CW'(BURST_LEN);
    localparam logic [PW-1:0] LAST_POP    = PW'(BURST_LEN - 1);

    cam_state_t     state;
    cam_state_t     state_nxt;
    logic           byte_phase;
    logic [7:0]     byte_hold;
    logic           vsync_q;
    logic           vsync_rise;
    logic           flush_pend;
    logic [PW-1:0]  pop_cnt;
    logic           flushing;
    logic           push;
    logic [15:0]    push_word;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;

    assign flushing   = (state == S_FLUSH);
    assign vsync_rise = vsync & ~vsync_q;
    // Bytes arriving while the FIFO is being flushed belong to neither frame.
    assign push       = pix_valid & byte_phase & ~flushing;

`ifdef CAM_BYTE_SWAP_EN
    assign push_word = {pix_data, byte_hold};
`else
    assign push_word = {byte_hold, pix_data};
`endif

    cam_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk80),
        .rst       (rst),
        .clr       (flushing),
        .push      (push),
        .push_data (push_word),
        .pop       (data_rd),
        .pop_data  (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush_pend)                state_nxt = S_FLUSH;
                else if (count >= BURST_WORDS) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (go && wr) state_nxt = S_BURST;
            end
            S_BURST: begin
                if (data_rd && pop_cnt == LAST_POP) state_nxt = S_IDLE;
            end
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk80 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cam_req    <= 1'b0;
            byte_phase <= 1'b0;
            byte_hold  <= '0;
            vsync_q    <= 1'b0;
            flush_pend <= 1'b0;
            pop_cnt    <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_q <= vsync;
            // Request drops the cycle after the grant is sampled.
            cam_req <= (state == S_REQ) && !(go && wr);

            // A new frame edge wins over the clear so it is never lost.
            if (vsync_rise)                flush_pend <= 1'b1;
            else if (state_nxt == S_FLUSH) flush_pend <= 1'b0;

            if (state == S_BURST) begin
                if (data_rd) pop_cnt <= (pop_cnt == LAST_POP) ? '0 : pop_cnt + 1'b1;
            end else begin
                pop_cnt <= '0;
            end

            if (flushing) begin
                byte_phase <= 1'b0;
                overflow   <= 1'b0;
                underflow  <= 1'b0;
            end else begin
                if (pix_valid) begin
                    byte_phase <= ~byte_phase;
                    if (!byte_phase) byte_hold <= pix_data;
                end
                if (push && full && !data_rd) overflow  <= 1'b1;
                if (data_rd && empty)         underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_burst_buf.sv
// Directed bench for cam_burst_buf with a scoreboard queue of expected burst words.
// Latency: n/a.
// Backpressure: n/a.
module tb_cam_burst_buf;
    import cam_burst_pkg::*;

    localparam int BL = 32;
    localparam int DP = 64;

    logic        clk80     = 1'b0;
    logic        rst       = 1'b1;
    logic [7:0]  pix_data  = '0;
    logic        pix_valid = 1'b0;
    logic        vsync     = 1'b0;
    logic        go        = 1'b0;
    logic        wr        = 1'b0;
    logic        data_rd   = 1'b0;
    logic [15:0] wr_data;
    logic        cam_req;
    logic        overflow;
    logic        underflow;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    int          mdl_cnt   = 0;
    bit          mdl_phase = 1'b0;
    logic [7:0]  mdl_hold  = '0;

    cam_burst_buf #(.BURST_LEN(BL), .DEPTH(DP)) dut (
        .clk80     (clk80),
        .rst       (rst),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .vsync     (vsync),
        .go        (go),
        .wr        (wr),
        .data_rd   (data_rd),
        .wr_data   (wr_data),
        .cam_req   (cam_req),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk80 = ~clk80;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk80);
        #1;
    endtask

    task automatic model_clear;
        sb.delete();
        mdl_cnt   = 0;
        mdl_phase = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [15:0] w;
        pix_data  = b;
        pix_valid = 1'b1;
        if (mdl_phase) begin
`ifdef CAM_BYTE_SWAP_EN
            w = {b, mdl_hold};
`else
            w = {mdl_hold, b};
`endif
            if (mdl_cnt < DP) begin
                sb.push_back(w);
                mdl_cnt++;
            end
        end else begin
            mdl_hold = b;
        end
        mdl_phase = ~mdl_phase;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic pop_one(input string tag);
        logic [15:0] e;
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (mdl_cnt > 0) mdl_cnt--;
        data_rd = 1'b1;
        chk(tag, 32'(wr_data), 32'(e));
        tick();
        data_rd = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (cam_req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(cam_req), 32'd1);
    endtask

    task automatic grant(input string tag);
        go = 1'b1;
        wr = 1'b1;
        tick();
        go = 1'b0;
        wr = 1'b0;
        chk(tag, 32'(cam_req), 32'd0);
        chk({tag, "_st"}, 32'(dut.state), 32'(S_BURST));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_req",   32'(cam_req),   32'd0);
        chk("rst_data",  32'(wr_data),   32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_udf",   32'(underflow), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(S_IDLE));
        chk("rst_count", 32'(dut.count), 32'd0);
        rst = 1'b0;
        tick();

        // Packing and request latency
        for (int i = 0; i < 64; i++) send_byte(8'(i));
        chk("pk_count", 32'(dut.count), 32'd32);
        chk("pk_req0",  32'(cam_req),   32'd0);
        tick();
        chk("pk_req1",  32'(cam_req),   32'd0);
        tick();
        chk("pk_req2",  32'(cam_req),   32'd1);

        // VGA read grant is ignored
        go = 1'b1;
        wr = 1'b0;
        tick();
        go = 1'b0;
        chk("vga_req", 32'(cam_req),   32'd1);
        chk("vga_st",  32'(dut.state), 32'(S_REQ));

        grant("pk_grant");
        for (int i = 0; i < BL; i++) pop_one("pk_pop");
        chk("pk_end_st",  32'(dut.state), 32'(S_IDLE));
        chk("pk_end_cnt", 32'(dut.count), 32'd0);

        // Overflow: 65 words with no grant, last one dropped
        for (int i = 0; i < 130; i++) send_byte(8'(8'h40 + i));
        chk("of_count", 32'(dut.count), 32'd64);
        chk("of_flag",  32'(overflow),  32'd1);
        grant("of_grant1");
        for (int i = 0; i < BL; i++) pop_one("of_pop1");
        chk("of_mid_cnt", 32'(dut.count), 32'd32);
        wait_req("of_req2");
        grant("of_grant2");
        for (int i = 0; i < BL; i++) pop_one("of_pop2");
        chk("of_end_cnt", 32'(dut.count), 32'd0);
        chk("of_sticky",  32'(overflow),  32'd1);

        // vsync mid-burst: burst completes, then flush
        for (int i = 0; i < 64; i++) send_byte(8'(8'hA0 + i));
        wait_req("vs_req");
        grant("vs_grant");
        for (int i = 0; i < 10; i++) pop_one("vs_pop_a");
        send_byte(8'hEE);
        vsync = 1'b1;
        tick();
        chk("vs_still_burst", 32'(dut.state), 32'(S_BURST));
        for (int i = 0; i < 22; i++) pop_one("vs_pop_b");
        chk("vs_idle", 32'(dut.state), 32'(S_IDLE));
        tick();
        chk("vs_flush", 32'(dut.state), 32'(S_FLUSH));
        tick();
        model_clear();
        chk("vs_post_st",  32'(dut.state), 32'(S_IDLE));
        chk("vs_post_cnt", 32'(dut.count), 32'd0);
        chk("vs_post_ovf", 32'(overflow),  32'd0);
        chk("vs_post_udf", 32'(underflow), 32'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("vs_phase_cnt", 32'(dut.count), 32'd1);
        chk("vs_phase_word", 32'(wr_data), 32'(sb[0]));

        // Underflow: only 16 words left when the burst starts
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        tick();
        tick();
        model_clear();
        chk("uf_flush_cnt", 32'(dut.count), 32'd0);
        for (int i = 0; i < 64; i++) send_byte(8'(i * 3));
        wait_req("uf_req");
        for (int i = 0; i < 16; i++) pop_one("uf_pre_pop");
        chk("uf_req_st", 32'(dut.state), 32'(S_REQ));
        grant("uf_grant");
        for (int i = 0; i < BL; i++) pop_one("uf_pop");
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_st",   32'(dut.state), 32'(S_IDLE));
        chk("uf_cnt",  32'(dut.count), 32'd0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 64; i++) send_byte(8'(8'hC0 + i));
        wait_req("ar_req");
        grant("ar_grant");
        for (int i = 0; i < 5; i++) pop_one("ar_pop");
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req0",  32'(cam_req),   32'd0);
        chk("ar_cnt",   32'(dut.count), 32'd0);
        chk("ar_data",  32'(wr_data),   32'd0);
        chk("ar_udf",   32'(underflow), 32'd0);
        chk("ar_state", 32'(dut.state), 32'(S_IDLE));
        model_clear();
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_burst_buf.md
# cam_burst_buf

Camera-side write buffer between the synchronized OV5642 pixel byte stream and the SDRAM burst arbiter, clocked on clk80. It packs byte pairs into 16-bit pixel words and queues them in an internal FIFO. Once a full burst is buffered it raises `cam_req` to the arbiter, then supplies one word per `data_rd` pop while the memory controller performs the write burst. Frame starts (vsync) flush stale data so that every frame begins burst-aligned in memory.

## Interface
- `BURST_LEN`, default 32: words per write burst; matches the arbiter's 32-word address stride.
- `DEPTH`, default 64: FIFO depth in words; must be a power of two and ≥ 2*BURST_LEN.
- `clk80`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `pix_data`  in  8: camera byte, already synchronized to clk80.
- `pix_valid`  in  1: one-cycle strobe, qualifies `pix_data`.
- `vsync`  in  1: frame sync, synchronized to clk80; rising edge marks frame start.
- `go`  in  1: arbiter Go.
- `wr`  in  1: arbiter Wr; a grant is `go & wr` (camera write burst).
- `data_rd`  in  1: pop strobe from the memory controller, one per burst word.
- `wr_data`  out  16: FIFO head word (first-word-fall-through).
- `cam_req`  out  1: burst request to the arbiter.
- `overflow`  out  1: sticky; a word was dropped because the FIFO was full.
- `underflow`  out  1: sticky; `data_rd` arrived while the FIFO was empty.

## Operation
- **Byte packing.**
  - A `byte_phase` flag toggles on each `pix_valid`.
  - Phase 0 latches the byte; phase 1 completes the word and pushes it.
  - Default order: first byte goes to [15:8], second byte to [7:0].
- **FIFO.** Occupancy `count` is $clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.
- **State machine** (states: S_IDLE, S_REQ, S_BURST, S_FLUSH):
  - **S_IDLE:**
    - If a flush is pending → S_FLUSH.
    - Else if `count` ≥ BURST_LEN → S_REQ.
  - **S_REQ:**
    - `cam_req` = 1.
    - On `go & wr` → S_BURST, with `cam_req` = 0 from the next cycle.
    - `go & ~wr` (VGA read) is ignored.
  - **S_BURST:**
    - A pop counter increments on each `data_rd`.
    - After the BURST_LEN-th pop → S_IDLE. A new request may follow immediately.
  - **S_FLUSH:**
    - Read and write pointers are cleared; `count` = 0, `byte_phase` = 0.
    - `overflow` and `underflow` are cleared.
    - Next state is S_IDLE.
- **vsync rising edge.** Sets `flush_pend` in any state.
  - It is serviced only from S_IDLE.
  - In S_REQ or S_BURST the current burst completes first, so the arbiter never sees a withdrawn request.
  - `flush_pend` clears on entry to S_FLUSH.
- **Full FIFO.** A completed word while `count` == DEPTH is dropped and `overflow` is set. A simultaneous pop frees the slot, so the word is accepted.
- **Empty FIFO.** A pop while `count` == 0:
  - sets `underflow`;
  - leaves the pointers unchanged;
  - still advances the pop counter;
  - drives `wr_data` = 16'h0000.
- **Simultaneous push and pop.** `count` is unchanged and both pointers advance.
- **Pixel input during S_FLUSH.** A `pix_valid` arriving during S_FLUSH is discarded.

## Timing
- **Reset values:**
  - state = S_IDLE; `cam_req` = 0; `wr_data` = 0 (empty); `overflow` = 0; `underflow` = 0.
  - Pointers, `count`, `byte_phase` and `flush_pend` are all 0.
- **Push latency.** The word is written on the clock edge that samples the second `pix_valid`. `count` and `wr_data` (if the FIFO was empty) update in the following cycle.
- **Request latency.**
  - S_IDLE→S_REQ takes one cycle after `count` reaches BURST_LEN.
  - `cam_req` is registered and goes high in the cycle after the state change.
- **Grant.** `go & wr` sampled in S_REQ. `cam_req` is low one cycle later; no further grant qualification is needed.
- **Pop.** `wr_data` is valid in the same cycle as `data_rd`. The next word appears in the cycle after the pop.
- **Reset mid-burst.** Returns immediately to the reset values and drops all FIFO contents.

## Configuration
- Macro `CAM_BYTE_SWAP_EN`.
  - **Defined:** first byte goes to [7:0], second byte to [15:8], for little-endian pixel formats.
  - **Undefined:** first byte goes to [15:8] (OV5642 RGB565 default).
- No other behaviour changes.

## Structure
- **Package `cam_burst_pkg`** contains:
  - the state enum (S_IDLE, S_REQ, S_BURST, S_FLUSH);
  - `CAM_BURST_LEN` = 32 and `CAM_FIFO_DEPTH` = 64;
  - the address stride constant of 32, shared with the arbiter.
- **Sub-module `cam_sync_fifo`:**
  - single-clock, first-word-fall-through, parameterized on DEPTH and width;
  - exposes full, empty, count and a synchronous clear.
- The top level keeps the packer, the FSM and the flags.

## Test plan
- **Packing:** 64 bytes 0x00..0x3F → 32 words 0x0001, 0x0203, …, 0x3E3F; `cam_req` = 1 two cycles after the 64th byte. With `CAM_BYTE_SWAP_EN` the first word is 0x0100.
- **Grant handling:**
  - `go` = 1, `wr` = 0 in S_REQ → `cam_req` stays 1.
  - `go` = 1, `wr` = 1 → `cam_req` = 0 next cycle.
  - 32 pops return the words in order; then state = S_IDLE with `count` = 0.
- **Overflow:** 130 bytes with no grant → `count` = 64, `overflow` = 1, and the 65th word is absent from the burst data.
- **Underflow:** 16 words buffered, force S_BURST, then 32 pops → the last 16 reads are 0x0000, `underflow` = 1, final state S_IDLE.
- **vsync mid-burst:** vsync rises after pop 10 → the remaining 22 pops complete normally, then S_FLUSH. Afterwards `count` = 0, flags clear, and the next byte is treated as phase 0.
- **Async reset mid-burst:** assert `rst` → `cam_req` = 0, `count` = 0 within the same cycle.
